// File: rtl/lzrw1_stream_sequencer.sv
// rtl/lzrw1_stream_sequencer.sv - parses an LZRW1 byte stream into literal/copy items for decompressor_top
// One item is held and presented at a time; a fixed GAP cycle after each issue absorbs the decompressor's busy latency.
module lzrw1_stream_sequencer #(
    parameter int COUNT_WIDTH = 16,
    parameter int CTRL_BITS   = 8
) (
    input  logic                   clock,
    input  logic                   reset,
    input  logic                   start,
    input  logic                   abort,
    input  logic [7:0]             s_byte,
    input  logic                   s_valid,
    input  logic                   s_last,
    output logic                   s_ready,
    output logic [15:0]            dec_data_in,
    output logic                   dec_control_word_in,
    output logic                   dec_data_in_valid,
    input  logic                   dec_busy,
    output logic                   busy,
    output logic                   done,
    output logic                   error,
    output logic [COUNT_WIDTH-1:0] item_count,
    output logic [COUNT_WIDTH-1:0] byte_count
);

    localparam logic [2:0] S_IDLE  = 3'd0;
    localparam logic [2:0] S_CTRL  = 3'd1;
    localparam logic [2:0] S_B0    = 3'd2;
    localparam logic [2:0] S_B1    = 3'd3;
    localparam logic [2:0] S_ISSUE = 3'd4;
    localparam logic [2:0] S_GAP   = 3'd5;
    localparam logic [2:0] S_DONE  = 3'd6;
    localparam logic [2:0] S_ERR   = 3'd7;

    localparam logic [2:0] LAST_BIT = 3'(CTRL_BITS - 1);

    logic [2:0]             state_q, state_d;
    logic [7:0]             ctrl_q, ctrl_d;
    logic [2:0]             bit_idx_q, bit_idx_d;
    logic [15:0]            hold_q, hold_d;
    logic                   last_item_q, last_item_d;
    logic                   done_q, done_d;
    logic [COUNT_WIDTH-1:0] item_cnt_q, item_cnt_d;
    logic [COUNT_WIDTH-1:0] byte_cnt_q, byte_cnt_d;

    logic accept;
    logic cur_bit;

    assign s_ready = (state_q == S_CTRL) || (state_q == S_B0) || (state_q == S_B1);
    assign accept  = s_valid && s_ready;
    assign cur_bit = ctrl_q[bit_idx_q];

    always_comb begin
        state_d     = state_q;
        ctrl_d      = ctrl_q;
        bit_idx_d   = bit_idx_q;
        hold_d      = hold_q;
        last_item_d = last_item_q;
        done_d      = 1'b0;
        item_cnt_d  = item_cnt_q;
        byte_cnt_d  = byte_cnt_q;

        if (accept && (byte_cnt_q != '1)) begin
            byte_cnt_d = byte_cnt_q + 1'b1;
        end

        case (state_q)
            S_IDLE, S_DONE, S_ERR: begin
                if (start) begin
                    state_d     = S_CTRL;
                    ctrl_d      = 8'h00;
                    bit_idx_d   = 3'd0;
                    hold_d      = 16'h0000;
                    last_item_d = 1'b0;
                    item_cnt_d  = '0;
                    byte_cnt_d  = '0;
                end
            end
            S_CTRL: begin
                if (accept) begin
                    ctrl_d    = s_byte;
                    bit_idx_d = LAST_BIT;
                    if (s_last) begin
                        state_d = S_DONE;
                        done_d  = 1'b1;
                    end else begin
                        state_d = S_B0;
                    end
                end
            end
            S_B0: begin
                if (accept) begin
                    if (cur_bit) begin
                        hold_d[15:8] = s_byte;
                        state_d      = s_last ? S_ERR : S_B1;
                    end else begin
                        hold_d      = {8'h00, s_byte};
                        last_item_d = s_last;
                        state_d     = S_ISSUE;
                    end
                end
            end
            S_B1: begin
                if (accept) begin
                    hold_d[7:0] = s_byte;
                    last_item_d = s_last;
                    state_d     = S_ISSUE;
                end
            end
            S_ISSUE: begin
                if (!dec_busy) begin
                    if (item_cnt_q != '1) begin
                        item_cnt_d = item_cnt_q + 1'b1;
                    end
                    state_d = S_GAP;
                end
            end
            S_GAP: begin
                if (last_item_q) begin
                    state_d = S_DONE;
                    done_d  = 1'b1;
                end else if (bit_idx_q == 3'd0) begin
                    state_d = S_CTRL;
                end else begin
                    bit_idx_d = bit_idx_q - 1'b1;
                    state_d   = S_B0;
                end
            end
            default: state_d = S_IDLE;
        endcase

        // Abort wins over everything, including a byte accepted this cycle.
        if (abort) begin
            state_d     = S_IDLE;
            ctrl_d      = 8'h00;
            bit_idx_d   = 3'd0;
            hold_d      = 16'h0000;
            last_item_d = 1'b0;
            done_d      = 1'b0;
            item_cnt_d  = '0;
            byte_cnt_d  = '0;
        end
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state_q     <= S_IDLE;
            ctrl_q      <= 8'h00;
            bit_idx_q   <= 3'd0;
            hold_q      <= 16'h0000;
            last_item_q <= 1'b0;
            done_q      <= 1'b0;
            item_cnt_q  <= '0;
            byte_cnt_q  <= '0;
        end else begin
            state_q     <= state_d;
            ctrl_q      <= ctrl_d;
            bit_idx_q   <= bit_idx_d;
            hold_q      <= hold_d;
            last_item_q <= last_item_d;
            done_q      <= done_d;
            item_cnt_q  <= item_cnt_d;
            byte_cnt_q  <= byte_cnt_d;
        end
    end

    assign dec_data_in         = hold_q;
    assign dec_control_word_in = cur_bit;
    assign dec_data_in_valid   = (state_q == S_ISSUE) && !dec_busy;
    assign busy                = !((state_q == S_IDLE) || (state_q == S_DONE) || (state_q == S_ERR));
    assign done                = done_q;
    assign error               = (state_q == S_ERR);
    assign item_count          = item_cnt_q;
    assign byte_count          = byte_cnt_q;

endmodule

// File: tb/tb_lzrw1_stream_sequencer.sv
// tb/tb_lzrw1_stream_sequencer.sv - self-checking bench for lzrw1_stream_sequencer
module tb_lzrw1_stream_sequencer;

    logic        clock;
    logic        reset;
    logic        start;
    logic        abort;
    logic [7:0]  s_byte;
    logic        s_valid;
    logic        s_last;
    logic        s_ready;
    logic [15:0] dec_data_in;
    logic        dec_control_word_in;
    logic        dec_data_in_valid;
    logic        dec_busy;
    logic        busy;
    logic        done;
    logic        error;
    logic [15:0] item_count;
    logic [15:0] byte_count;

    lzrw1_stream_sequencer #(.COUNT_WIDTH(16), .CTRL_BITS(8)) dut (
        .clock               (clock),
        .reset               (reset),
        .start               (start),
        .abort               (abort),
        .s_byte              (s_byte),
        .s_valid             (s_valid),
        .s_last              (s_last),
        .s_ready             (s_ready),
        .dec_data_in         (dec_data_in),
        .dec_control_word_in (dec_control_word_in),
        .dec_data_in_valid   (dec_data_in_valid),
        .dec_busy            (dec_busy),
        .busy                (busy),
        .done                (done),
        .error               (error),
        .item_count          (item_count),
        .byte_count          (byte_count)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    typedef struct {
        logic [0:15][7:0] b;
        int               n;
        int               exp_items;
        int               exp_bytes;
        logic             exp_err;
        bit               no_gaps;
    } vec_t;

    int errors = 0;
    int checks = 0;

    logic [7:0]  stream[$];
    logic [16:0] exp_q[$];
    logic        exp_err;
    logic [16:0] got_q[$];
    int          got_cyc[$];
    int          cyc = 0;
    int          done_cnt = 0;
    int          viol = 0;
    int          busy_mode = 1;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    // Reference decode of a whole byte stream: walk control bytes MSB first.
    function automatic void model();
        int i;
        logic [7:0] c;
        exp_q.delete();
        exp_err = 1'b0;
        i = 0;
        while (i < stream.size() && !exp_err) begin
            c = stream[i];
            i++;
            for (int k = 7; k >= 0; k--) begin
                if (i >= stream.size() || exp_err) break;
                if (c[k] == 1'b0) begin
                    exp_q.push_back({1'b0, 8'h00, stream[i]});
                    i++;
                end else if (i + 1 >= stream.size()) begin
                    exp_err = 1'b1;
                end else begin
                    exp_q.push_back({1'b1, stream[i], stream[i+1]});
                    i += 2;
                end
            end
        end
    endfunction

    initial begin
        dec_busy = 1'b0;
        forever begin
            @(negedge clock);
            case (busy_mode)
                0: dec_busy = ($urandom_range(0, 2) == 0);
                1: dec_busy = 1'b0;
                default: dec_busy = 1'b1;
            endcase
        end
    end

    initial begin
        forever begin
            @(negedge clock);
            #2;
            cyc++;
            if (dec_data_in_valid) begin
                if (dec_busy) viol++;
                got_q.push_back({dec_control_word_in, dec_data_in});
                got_cyc.push_back(cyc);
            end
            if (done) done_cnt++;
        end
    end

    task automatic begin_stream();
        got_q.delete();
        got_cyc.delete();
        done_cnt = 0;
        viol = 0;
        @(negedge clock);
        start = 1'b1;
        @(negedge clock);
        start = 1'b0;
        #2;
        chk("start_clears", {error, busy, item_count, byte_count}, {1'b0, 1'b1, 32'h0});
    endtask

    task automatic drive_bytes(input int upto, input bit no_gaps);
        int idx = 0;
        int guard = 0;
        bit acc = 0;
        while (idx < upto && guard < 4000) begin
            @(negedge clock);
            if (acc) idx++;
            acc = 0;
            if (idx < upto) begin
                s_valid = no_gaps ? 1'b1 : ($urandom_range(0, 2) != 0);
                s_byte  = stream[idx];
                s_last  = (idx == stream.size() - 1);
                acc     = s_valid && s_ready;
            end else begin
                s_valid = 1'b0;
                s_last  = 1'b0;
            end
            guard++;
        end
        if (guard >= 4000) chk("drive_timeout", 1, 0);
    endtask

    task automatic finish_stream(input bit check_spacing);
        int w = 0;
        while (busy && w < 500) begin
            @(negedge clock);
            w++;
        end
        chk("finish_timeout", (w >= 500), 0);
        @(negedge clock);
        #3;
        model();
        chk("error_flag", error, exp_err);
        chk("done_pulses", done_cnt, exp_err ? 0 : 1);
        chk("item_count", item_count, exp_q.size());
        chk("byte_count", byte_count, stream.size());
        chk("issued_items", got_q.size(), exp_q.size());
        chk("valid_while_busy", viol, 0);
        for (int k = 0; k < exp_q.size(); k++) begin
            if (k < got_q.size()) chk($sformatf("item[%0d]", k), got_q[k], exp_q[k]);
        end
        if (check_spacing) begin
            for (int k = 1; k < got_cyc.size(); k++)
                chk($sformatf("spacing[%0d]", k), got_cyc[k] - got_cyc[k-1], 3);
        end
    endtask

    vec_t vecs[5];

    initial begin
        int bad;
        int len;
        reset = 1'b0;
        start = 1'b0;
        abort = 1'b0;
        s_byte = 8'h00;
        s_valid = 1'b0;
        s_last = 1'b0;

        vecs[0] = '{b: {8'h00, 8'h61, 8'h62, 8'h63, 8'h64, 8'h65, 8'h66, 8'h67, 8'h68, 56'h0},
                    n: 9, exp_items: 8, exp_bytes: 9, exp_err: 1'b0, no_gaps: 1'b1};
        vecs[1] = '{b: {8'h40, 8'h41, 8'h12, 8'h34, 8'h42, 88'h0},
                    n: 5, exp_items: 3, exp_bytes: 5, exp_err: 1'b0, no_gaps: 1'b0};
        vecs[2] = '{b: {8'h80, 8'h12, 112'h0},
                    n: 2, exp_items: 0, exp_bytes: 2, exp_err: 1'b1, no_gaps: 1'b0};
        vecs[3] = '{b: {8'h00, 8'h01, 8'h02, 8'h03, 8'h04, 8'h05, 8'h06, 8'h07, 8'h08,
                        8'hFF, 8'hAB, 8'hCD, 32'h0},
                    n: 12, exp_items: 9, exp_bytes: 12, exp_err: 1'b0, no_gaps: 1'b0};
        vecs[4] = '{b: {8'h55, 120'h0},
                    n: 1, exp_items: 0, exp_bytes: 1, exp_err: 1'b0, no_gaps: 1'b0};

        repeat (3) @(negedge clock);
        #2;
        chk("reset_outputs", {s_ready, dec_data_in, dec_control_word_in, dec_data_in_valid,
                              busy, done, error, item_count, byte_count}, 64'h0);
        reset = 1'b1;

        foreach (vecs[v]) begin
            busy_mode = vecs[v].no_gaps ? 1 : 0;
            stream.delete();
            for (int i = 0; i < vecs[v].n; i++) stream.push_back(vecs[v].b[i]);
            begin_stream();
            drive_bytes(vecs[v].n, vecs[v].no_gaps);
            finish_stream(vecs[v].no_gaps);
            chk($sformatf("vec%0d_items", v), item_count, vecs[v].exp_items);
            chk($sformatf("vec%0d_bytes", v), byte_count, vecs[v].exp_bytes);
            chk($sformatf("vec%0d_err", v), error, vecs[v].exp_err);
        end

        // Decompressor held busy for 20 cycles while an item waits in ISSUE.
        busy_mode = 2;
        stream = '{8'h00, 8'h61};
        begin_stream();
        drive_bytes(2, 1'b1);
        bad = 0;
        repeat (20) begin
            @(negedge clock);
            #2;
            if (dec_data_in_valid || dec_data_in !== 16'h0061 || !busy) bad++;
        end
        chk("stall_held", bad, 0);
        busy_mode = 1;
        @(negedge clock);
        #2;
        chk("stall_release_valid", {dec_data_in_valid, dec_control_word_in, dec_data_in}, {2'b10, 16'h0061});
        @(negedge clock);
        #2;
        chk("stall_single_valid", dec_data_in_valid, 1'b0);
        finish_stream(1'b0);

        // Abort while parked in B1 with a byte offered in the same cycle.
        busy_mode = 0;
        stream = '{8'h80, 8'h12, 8'h34};
        begin_stream();
        drive_bytes(2, 1'b0);
        s_valid = 1'b1;
        s_byte  = 8'h34;
        s_last  = 1'b1;
        abort   = 1'b1;
        @(negedge clock);
        abort   = 1'b0;
        s_valid = 1'b0;
        s_last  = 1'b0;
        #2;
        chk("abort_outputs", {s_ready, dec_data_in, dec_control_word_in, dec_data_in_valid,
                              busy, done, error, item_count, byte_count}, 64'h0);

        for (int r = 0; r < 30; r++) begin
            busy_mode = 0;
            len = $urandom_range(1, 16);
            stream.delete();
            for (int i = 0; i < len; i++) stream.push_back(8'($urandom));
            begin_stream();
            drive_bytes(len, 1'b0);
            finish_stream(1'b0);
        end

        // Asynchronous reset while an item is being presented.
        busy_mode = 1;
        stream = '{8'h00, 8'h61, 8'h62};
        begin_stream();
        drive_bytes(2, 1'b1);
        #3;
        chk("pre_reset_valid", dec_data_in_valid, 1'b1);
        reset = 1'b0;
        #1;
        chk("async_reset_clears", {dec_data_in_valid, busy, item_count, byte_count}, 34'h0);
        @(negedge clock);
        reset = 1'b1;
        @(negedge clock);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/lzrw1_stream_sequencer.md
Name: lzrw1_stream_sequencer

Overview:
Sequences a raw LZRW1-format compressed byte stream into the item-level interface of decompressor_top. It parses control bytes, assembles 1-byte literal or 2-byte copy items, and issues each one with the matching control bit. Issue is paced by decompressor_busy, so the decompressor never receives an item while busy. It sits between the memory/DMA byte source and decompressor_top.

Parameters:
COUNT_WIDTH, 16, width of the issued-item and consumed-byte counters.
CTRL_BITS, 8, items per control byte (fixed at 8; any other value is unsupported).

Ports:
clock  input  1  system clock.
reset  input  1  asynchronous, active-low reset.
start  input  1  1-cycle pulse; begins a new stream; ignored unless state is IDLE, DONE or ERR.
abort  input  1  synchronous; forces IDLE next cycle from any state.
s_byte  input  8  compressed stream byte.
s_valid  input  1  s_byte valid.
s_last  input  1  qualifies the final byte of the stream.
s_ready  output  1  byte accepted when s_valid && s_ready.
dec_data_in  output  16  to decompressor_top data_in.
dec_control_word_in  output  1  to decompressor_top control_word_in (1 = copy, 0 = literal).
dec_data_in_valid  output  1  to decompressor_top data_in_valid.
dec_busy  input  1  from decompressor_top decompressor_busy.
busy  output  1  high in every state except IDLE, DONE and ERR.
done  output  1  1-cycle pulse on entry to DONE.
error  output  1  high while in ERR.
item_count  output  COUNT_WIDTH  items issued since start; saturates at all-ones.
byte_count  output  COUNT_WIDTH  bytes consumed since start; saturates at all-ones.

Behaviour:
- Reset (reset=0) and abort:
  - state=IDLE.
  - All outputs 0: s_ready, dec_data_in, dec_control_word_in, dec_data_in_valid, busy, done, error, item_count, byte_count.
  - Internal registers cleared: control byte, bit index, item holding register.
- Stream format:
  - Control byte, then up to 8 items, then repeat.
  - Control bits are consumed MSB first (bit 7 = first item).
  - Literal: 1 byte; dec_data_in = {8'h00, byte}.
  - Copy: 2 bytes; dec_data_in = {first_byte, second_byte}.
- States:
  - IDLE: on start, clear counters, go to CTRL.
  - CTRL: s_ready=1. On accept, latch control byte, bit_idx=7.
    - s_last on the control byte -> DONE.
    - Otherwise -> B0.
  - B0: s_ready=1. On accept, latch byte into hold[15:8].
    - Control bit 0 (literal): move it to hold[7:0] with hold[15:8]=0, go to ISSUE.
    - Control bit 1 (copy): go to B1.
    - s_last with control bit 0: flag last_item.
    - s_last with control bit 1: go to ERR (truncated copy).
  - B1: s_ready=1. On accept, hold[7:0]=byte, go to ISSUE; s_last flags last_item.
  - ISSUE: s_ready=0. dec_data_in and dec_control_word_in are driven from hold and the current control bit (registered; stable for the whole state).
    - dec_data_in_valid = (state==ISSUE) && !dec_busy.
    - In the first cycle valid is high, increment item_count and go to GAP.
  - GAP: exactly 1 cycle, valid=0; dec_busy is ignored, which covers the decompressor's busy-assert latency.
    - last_item set -> DONE.
    - Else bit_idx==0 -> CTRL.
    - Else bit_idx-- and -> B0.
  - DONE: done pulses on the entry cycle; hold state until start.
  - ERR: error=1 until start or abort.
- byte_count increments on every accepted byte.
- Every item is presented exactly once, for exactly one valid cycle. dec_data_in_valid is never high while dec_busy=1.
- Minimum latency: last byte of an item accepted in cycle N -> dec_data_in_valid in cycle N+1 if dec_busy=0.
- Maximum throughput: one literal per 3 cycles (B0, ISSUE, GAP).
- s_valid=0 stalls in CTRL, B0 or B1 indefinitely with no side effects.
- s_last on a literal or copy item completes that item's issue, then goes to DONE; the remaining control bits are discarded.
- start while busy=1 is ignored. abort takes priority over every transition, including an accept in the same cycle; that byte is not counted.
- Reset asserted mid-operation clears immediately (asynchronous); dec_data_in_valid drops in the same cycle.

Test Plan:
- Stream 0x00,'a','b','c','d','e','f','g','h'(last), dec_busy=0 -> 8 literals {8'h00,0x61..0x68}, control_word_in=0, valid pulses spaced 3 cycles apart; item_count=8, byte_count=9, done pulse.
- Stream 0x40,0x41,0x12,0x34,0x42(last) -> issues {00,41}/cw0, {1234}/cw1, {00,42}/cw0; item_count=3, byte_count=5, done.
- Hold dec_busy=1 for 20 cycles while in ISSUE -> dec_data_in_valid stays 0 throughout; single valid cycle on the first cycle dec_busy=0; data stable while stalled.
- Stream 0x80,0x12(last) -> no item issued; error=1, item_count=0, byte_count=2; subsequent start clears error.
- 9th-item boundary: 0x00, 8 literals, then 0xFF,0xAB,0xCD(last) -> second control byte parsed, 9th item {ABCD}/cw1 issued.
- Random s_valid gaps plus abort mid-B1 -> IDLE next cycle, all outputs 0; then a new start/stream decodes correctly.
